// File: rtl/base64_ascii_packer.sv
// Base64 sextet-to-ASCII mapper with output FIFO and message framing.
// Define B64_PAD_EN to terminate messages on a 4-char boundary with '=' fill.
module base64_ascii_packer #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] in_sextet,
  input  logic       in_valid,
  input  logic       flush,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       done,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          push, pop, full, space, drained;
  logic [7:0]    ascii, wdata;
`ifdef B64_PAD_EN
  logic [1:0]    grp_q, grp_d;
`endif

  function automatic logic [7:0] b64_map(input logic [5:0] v);
    logic [7:0] c;
    c = 8'h2F;
    unique case (1'b1)
      (v < 6'd26):                c = 8'h41 + {2'b00, v};
      (v >= 6'd26 && v < 6'd52):  c = 8'h61 + {2'b00, v} - 8'd26;
      (v >= 6'd52 && v < 6'd62):  c = 8'h30 + {2'b00, v} - 8'd52;
      (v == 6'd62):               c = 8'h2B;
      default:                    c = 8'h2F;
    endcase
    return c;
  endfunction

  assign ascii     = b64_map(in_sextet);
  assign out_valid = (cnt_q != '0);
  assign out_char  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign full      = (cnt_q == FULL_CNT);
  assign pop       = out_valid && out_ready;
  assign space     = !full || pop;
  assign drained   = (cnt_q == '0) || (cnt_q == CW'(1) && pop);
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
  assign done      = done_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    wdata   = ascii;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef B64_PAD_EN
    grp_d   = grp_q;
`endif
    case (state_q)
      IDLE, ACTIVE: begin
        if (in_valid) begin
          if (space) begin
            push    = 1'b1;
            state_d = ACTIVE;
`ifdef B64_PAD_EN
            grp_d   = grp_q + 2'd1;
`endif
          end else begin
            ovf_d = 1'b1;
          end
        end
        // flush sees grp after this cycle's sextet has been counted
        if (state_q == ACTIVE && flush) begin
`ifdef B64_PAD_EN
          state_d = (grp_d != 2'd0) ? PAD : DRAIN;
`else
          state_d = DRAIN;
`endif
        end
      end
`ifdef B64_PAD_EN
      PAD: begin
        if (in_valid) ovf_d = 1'b1;
        if (space) begin
          push  = 1'b1;
          wdata = 8'h3D;
          grp_d = grp_q + 2'd1;
          if (grp_d == 2'd0) state_d = DRAIN;
        end
      end
`endif
      default: begin
        if (in_valid) ovf_d = 1'b1;
        if (drained) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef B64_PAD_EN
          grp_d   = 2'd0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef B64_PAD_EN
      grp_q    <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
`ifdef B64_PAD_EN
      grp_q   <= grp_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: doc/base64_ascii_packer.md
BASE64_ASCII_PACKER -- requirements
Module: base64_ascii_packer

Interface
REQ-001 Parameter: DEPTH, 8, output FIFO entries; power of two, range 4..32.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_sextet  input  6  base64 index 0..63 from the upstream bit-to-sextet converter.
REQ-005 Port: in_valid  input  1  one-cycle strobe; in_sextet is valid in that cycle.
REQ-006 Port: flush  input  1  one-cycle end-of-message strobe.
REQ-007 Port: out_char  output  8  ASCII character at the FIFO head.
REQ-008 Port: out_valid  output  1  out_char is valid (FIFO not empty).
REQ-009 Port: out_ready  input  1  downstream accepts out_char.
REQ-010 Port: done  output  1  one-cycle pulse when a flushed message has fully drained.
REQ-011 Port: overflow  output  1  sticky flag; set when an input sextet is dropped.

Function
REQ-012 Mapping: index 0-25 -> 0x41+v; 26-51 -> 0x61+(v-26); 52-61 -> 0x30+(v-52); 62 -> 0x2B ('+'); 63 -> 0x2F ('/').
REQ-013 Mapping occurs at write time; the FIFO stores 8-bit ASCII characters.
REQ-014 Latency: in_valid sampled at edge N -> out_valid=1 with the mapped char after edge N, if the FIFO was empty.
REQ-015 Pop: occurs when out_valid and out_ready at an edge; out_char/out_valid are driven directly from FIFO registers (no combinational path from inputs).
REQ-016 Push when full: accepted only if a pop occurs at the same edge; otherwise the sextet is dropped and overflow is set.
REQ-017 Group counter grp (2 bits, mod 4): increments on every accepted character, including pad characters.
REQ-018 FSM states: IDLE, ACTIVE, PAD, DRAIN; IDLE->ACTIVE on the first accepted in_valid.
REQ-019 ACTIVE, flush=1: -> PAD if grp_next!=0 and padding is compiled in; otherwise -> DRAIN.
REQ-020 PAD: pushes '=' (0x3D) once per cycle while FIFO space is available; -> DRAIN when grp returns to 0.
REQ-021 DRAIN: -> IDLE when the FIFO becomes empty; done=1 for exactly that one cycle; grp cleared.
REQ-022 Simultaneous in_valid and flush: the sextet is accepted and counted first, then the flush is evaluated against the updated grp.
REQ-023 in_valid in PAD or DRAIN: the sextet is dropped and overflow is set.
REQ-024 flush in IDLE or PAD/DRAIN: ignored.
REQ-025 Pointers: wrap modulo DEPTH; full/empty are derived from a DEPTH+1-range occupancy count.

Reset
REQ-026 rst=1 immediately forces state=IDLE, FIFO empty, grp=0, out_valid=0, out_char=0x00, done=0, overflow=0.
REQ-027 Reset mid-message discards all buffered characters; no done pulse is produced.

Configuration
REQ-028 Macro: B64_PAD_EN.
- Defined: PAD state is present; messages end on a 4-character boundary with '=' fill.
- Undefined: PAD logic is removed; flush goes directly to DRAIN; grp is unused and no '=' is ever emitted.

Verification
REQ-029 Stream in_sextet 33, 51, 62, 0 with out_ready=1 -> out_char sequence 0x68, 0x7A, 0x2B, 0x41, each one cycle after its strobe.
REQ-030 Send 2 sextets (0, 63) then flush, with B64_PAD_EN defined -> chars 'A', '/', '=', '=' followed by a single done pulse; without the macro -> 'A', '/' then done.
REQ-031 out_ready=0 and 9 strobes with DEPTH=8 -> 8 chars held, overflow=1; release out_ready -> exactly 8 chars out.
REQ-032 FIFO full, with in_valid and out_ready high in the same cycle -> push accepted, occupancy stays 8, overflow stays 0.
REQ-033 in_valid (index 5) coincident with flush after 2 accepted chars -> 'F' then a single '=' (grp reaches 0).
REQ-034 Assert rst while in PAD with 3 chars buffered -> out_valid=0 immediately; done never pulses; next strobe of index 26 -> 'a'.
